// File: rtl/alu4_if.sv
// Request/result bundle for the alu4 registered ALU slice.
// The master side issues operands and opcode; the slave side returns the result and flags.
interface alu4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [3:0]       opr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] o;
    logic             out_valid;
    logic             carry;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, opr, a, b,
        input  o, out_valid, carry, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, opr, a, b,
        output o, out_valid, carry, zero, ovf, illegal
    );
endinterface

// File: rtl/alu4.sv
// 4-bit registered ALU: combinational datapath feeding a single bank of output registers.
// Result and flags load together on an accepted request and hold otherwise.
module alu4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    alu4_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd12;
    localparam logic [3:0] OP_DEC  = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_inc;
    logic [WIDTH:0]       w_dec;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic                 w_ovf;
    logic                 w_illegal;

    logic [WIDTH-1:0]     r_o;
    logic                 r_valid;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_illegal;

    // Extra top bit on add/sub/inc/dec carries the carry-out or borrow directly.
    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_inc  = {1'b0, bus.a} + (WIDTH+1)'(1);
    assign w_dec  = {1'b0, bus.a} - (WIDTH+1)'(1);
    assign w_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (bus.opr)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
            end
            OP_MUL: begin
                w_res   = w_prod[WIDTH-1:0];
                w_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_NAND: w_res = ~(bus.a & bus.b);
            OP_NOR:  w_res = ~(bus.a | bus.b);
            OP_XNOR: w_res = ~(bus.a ^ bus.b);
            OP_NOT:  w_res = ~bus.a;
            OP_INC: begin
                w_res   = w_inc[WIDTH-1:0];
                w_carry = w_inc[WIDTH];
                w_ovf   = ~bus.a[MSB] & w_inc[MSB];
            end
            OP_DEC: begin
                w_res   = w_dec[WIDTH-1:0];
                w_carry = w_dec[WIDTH];
                w_ovf   = bus.a[MSB] & ~w_dec[MSB];
            end
            OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o       <= '0;
            r_valid   <= 1'b0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_o       <= w_res;
                r_carry   <= w_carry;
                r_zero    <= (w_res == '0);
                r_ovf     <= w_ovf;
                r_illegal <= w_illegal;
            end
        end
    end

    assign bus.o         = r_o;
    assign bus.out_valid = r_valid;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu4.sv
// Directed bench for alu4: stimulus pushes hand-computed results into a queue,
// a monitor pops and compares whenever out_valid is seen.
module tb_alu4;
    logic clk;
    logic rst_n;

    alu4_if #(.WIDTH(4)) bus ();

    alu4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] exp;   // {o, carry, zero, ovf, illegal}
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pack_out();
        return {bus.o, bus.carry, bus.zero, bus.ovf, bus.illegal};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got o=%h c=%b z=%b v=%b ill=%b, need o=%h c=%b z=%b v=%b ill=%b",
                     nm, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b need %b", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [3:0] ia,
                         input logic [3:0] ib, input logic [3:0] eo,
                         input logic ec, input logic ez, input logic ev, input logic ei);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.opr      = op;
        bus.a        = ia;
        bus.b        = ib;
        e.name = nm;
        e.exp  = {eo, ec, ez, ev, ei};
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got out_valid=1 o=%h need no result", bus.o);
                end else begin
                    e = q.pop_front();
                    chk(e.name, pack_out(), e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] sweep_o [16] = '{4'h5, 4'h1, 4'h6, 4'h2, 4'h3, 4'h1, 4'hD, 4'hC,
                                 4'hE, 4'hC, 4'h0, 4'h0, 4'h4, 4'h2, 4'h1, 4'h0};

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.opr      = 4'd0;
        bus.a        = 4'd0;
        bus.b        = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", pack_out(), 8'h00);
        chk1("reset_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Opcode sweep a=3 b=2, back to back.
        for (int i = 0; i < 16; i++) begin
            issue($sformatf("sweep_op%0d", i), 4'(i), 4'h3, 4'h2, sweep_o[i],
                  1'b0, (sweep_o[i] == 4'h0), 1'b0, (i == 10 || i == 11));
        end

        // Arithmetic and compare edge cases.
        issue("add_F_1",  4'd0,  4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue("add_7_1",  4'd0,  4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        issue("sub_2_3",  4'd1,  4'h2, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("sub_8_1",  4'd1,  4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        issue("mul_5_4",  4'd2,  4'h5, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("inc_F",    4'd12, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue("inc_7",    4'd12, 4'h7, 4'h0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        issue("dec_0",    4'd13, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("dec_8",    4'd13, 4'h8, 4'h0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        issue("gt_2_3",   4'd14, 4'h2, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue("eq_9_9",   4'd15, 4'h9, 4'h9, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("gt_9_9",   4'd14, 4'h9, 4'h9, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue("rsv_after", 4'd11, 4'h9, 4'h9, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("mul_3_5",  4'd2,  4'h3, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hold: single request, then in_valid low with wandering inputs.
        issue("hold_add", 4'd0, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        bus.opr = 4'd2;
        bus.a   = 4'hC;
        bus.b   = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.opr = 4'(i + 5);
            bus.a   = 4'(i * 3);
            bus.b   = 4'hF;
            @(negedge clk);
            chk($sformatf("hold_o_%0d", i), pack_out(), 8'h20);
            chk1($sformatf("hold_valid_%0d", i), bus.out_valid, 1'b0);
        end

        // Async reset between clock edges.
        #2;
        chk("pre_reset_o", pack_out(), 8'h20);
        rst_n = 1'b0;
        #1;
        chk("async_reset_o", pack_out(), 8'h00);
        chk1("async_reset_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk1("post_release_valid", bus.out_valid, 1'b0);
        issue("xor_A_5", 4'd5, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results still pending, need 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu4.md
Name: alu4

Overview:
- 4-bit registered arithmetic/logic unit for small datapath slices.
- Operates on two 4-bit operands `a` and `b`, selected by a 4-bit opcode `opr`.
- Result and status flags are registered one clock after the request is sampled.
- Sits between operand registers and the writeback/status logic of its parent datapath.

Parameters:
- WIDTH, 4, operand/result width; all requirements below are stated for 4. Other values need not be supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request; operands and opcode are sampled when high
- opr  input  4  opcode
- a  input  4  operand A
- b  input  4  operand B
- o  output  4  registered result
- out_valid  output  1  high for one cycle when `o` and the flags hold a new result
- carry  output  1  carry/borrow flag
- zero  output  1  high when `o` == 0
- ovf  output  1  signed (two's-complement) overflow
- illegal  output  1  reserved opcode was issued

Behaviour:
- Reset: rst_n low immediately clears o, out_valid, carry, zero, ovf and illegal to 0, regardless of clk. Release is synchronous to the next clk edge.
- Latency: 1 cycle. If in_valid is high at edge N, the results appear after edge N.
  - out_valid is high for exactly that one cycle.
  - Back-to-back requests give back-to-back results; there is no stall.
- in_valid low: o and all flags hold their previous values, and out_valid goes to 0.
- Opcodes (all results truncated to 4 bits):
  - 0 ADD: o = a+b; carry = bit 4 of the sum; ovf = signed add overflow.
  - 1 SUB: o = a-b; carry = borrow (a<b, unsigned); ovf = signed subtract overflow.
  - 2 MUL: o = low nibble of a*b; carry = 1 if the upper nibble is nonzero.
  - 3 AND: o = a&b
  - 4 OR: o = a|b
  - 5 XOR: o = a^b
  - 6 NAND: o = ~(a&b)
  - 7 NOR: o = ~(a|b)
  - 8 XNOR: o = ~(a^b)
  - 9 NOT: o = ~a
  - 10, 11 reserved: o = 0, illegal = 1, other flags 0.
  - 12 INC: o = a+1; carry set on 0xF→0x0 wrap; ovf on 0x7→0x8.
  - 13 DEC: o = a-1; carry (borrow) set on 0x0→0xF; ovf on 0x8→0x7.
  - 14 GT: o = 4'b0001 if a > b (unsigned), else 0.
  - 15 EQ: o = 4'b0001 if a == b, else 0.
- Flag rules:
  - carry and ovf are 0 for every opcode that does not define them.
  - zero is computed from the new o on every accepted request, including reserved opcodes (zero = 1 there).
  - illegal is 0 for all defined opcodes.
  - Flags update only together with o.
- Combinational datapath; no internal state except the output registers.
- Reset asserted mid-operation discards any in-flight result; out_valid stays 0 until a new in_valid is sampled after release.

Test Plan:
- Sweep opcodes 0..15 with a=3, b=2 (one request per cycle, in_valid high):
  - o = 5, 1, 6, 2, 3, 1, D, C, E, C, 0, 0, 4, 2, 1, 0 (hex), one cycle after each request.
  - illegal = 1 only for opcodes 10 and 11.
- Arithmetic edge cases:
  - ADD a=F, b=1 → o=0, carry=1, zero=1, ovf=0.
  - ADD a=7, b=1 → o=8, ovf=1, carry=0.
  - SUB a=2, b=3 → o=F, carry=1.
  - SUB a=8, b=1 → o=7, ovf=1.
- MUL a=5, b=4 → o=4, carry=1. INC a=F → o=0, carry=1, zero=1. DEC a=0 → o=F, carry=1.
- Compares:
  - GT a=2, b=3 → o=0, zero=1.
  - EQ a=9, b=9 → o=1.
  - GT a=9, b=9 → o=0.
- Hold and valid handling: one request (ADD 1+1 → o=2), then in_valid low for 3 cycles with changing a/b/opr → o stays 2, out_valid is a single-cycle pulse.
- Async reset: assert rst_n low between clock edges while o=2 → o and all flags clear immediately. Release, then issue XOR a=A, b=5 → o=F one cycle later.
